data_bus_responder: RTL and testbench



---
 rtl/data_bus_responder.sv | 151 +++++++++++++++
 tb/tb_data_bus_responder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/data_bus_responder.sv
// Byte-enabled word responder for the core's load/store data bus.
// One request in flight: accept, wait WAIT_CYCLES, access the array, then hold the response.
module data_bus_responder #(
  parameter logic [31:0] BASE_ADDRESS = 32'h0001_0000,
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter int unsigned WAIT_CYCLES  = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_address,
  input  logic [3:0]  req_byte_enable,
  input  logic [31:0] req_write_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_read_data,
  output logic        resp_error
);

  localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned WORD_W = 30;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_ACCESS  = 2'd2,
    ST_RESPOND = 2'd3
  } state_t;

  state_t state, next_state;

  logic [31:0] mem [DEPTH_WORDS];

  logic [CNT_W-1:0] wait_cnt, wait_cnt_d;
  logic             req_ready_d, resp_valid_d, resp_error_d;
  logic [31:0]      resp_read_data_d;

  logic             lat_write, lat_err;
  logic [IDX_W-1:0] lat_idx;
  logic [3:0]       lat_be;
  logic [31:0]      lat_data;

  logic              accept_c, miss_c, be_ok_c, err_c, mem_we_c, unused_c;
  logic [WORD_W-1:0] word_c;

  // Range check happens on the full word offset so addresses below the base wrap high and miss.
  assign word_c   = req_address[31:2] - BASE_ADDRESS[31:2];
  assign miss_c   = (word_c >= WORD_W'(DEPTH_WORDS));
  assign err_c    = miss_c || !be_ok_c;
  assign accept_c = req_valid && req_ready;
  assign unused_c = ^req_address[1:0];
  assign mem_we_c = reset_n && (state == ST_ACCESS) && lat_write && !lat_err;

  always_comb begin
    be_ok_c = 1'b0;
    case (req_byte_enable)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: be_ok_c = 1'b1;
      default:                   be_ok_c = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (accept_c) next_state = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
      ST_WAIT:    if (wait_cnt == '0) next_state = ST_ACCESS;
      ST_ACCESS:  next_state = ST_RESPOND;
      ST_RESPOND: if (resp_ready) next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and the wait counter
  always_comb begin
    req_ready_d      = (next_state == ST_IDLE);
    resp_valid_d     = resp_valid;
    resp_error_d     = resp_error;
    resp_read_data_d = resp_read_data;
    wait_cnt_d       = wait_cnt;
    case (state)
      ST_IDLE: begin
        if (accept_c) wait_cnt_d = CNT_W'(WAIT_CYCLES - 1);
      end
      ST_WAIT: begin
        if (wait_cnt != '0) wait_cnt_d = wait_cnt - CNT_W'(1);
      end
      ST_ACCESS: begin
        resp_valid_d     = 1'b1;
        resp_error_d     = lat_err;
        resp_read_data_d = (!lat_write && !lat_err) ? mem[lat_idx] : 32'h0;
      end
      ST_RESPOND: begin
        if (resp_ready) begin
          resp_valid_d     = 1'b0;
          resp_error_d     = 1'b0;
          resp_read_data_d = 32'h0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_error     <= 1'b0;
      resp_read_data <= 32'h0;
      wait_cnt       <= '0;
      lat_write      <= 1'b0;
      lat_err        <= 1'b0;
      lat_idx        <= '0;
      lat_be         <= '0;
      lat_data       <= 32'h0;
    end else begin
      req_ready      <= req_ready_d;
      resp_valid     <= resp_valid_d;
      resp_error     <= resp_error_d;
      resp_read_data <= resp_read_data_d;
      wait_cnt       <= wait_cnt_d;
      if ((state == ST_IDLE) && accept_c) begin
        lat_write <= req_write;
        lat_err   <= err_c;
        lat_idx   <= word_c[IDX_W-1:0];
        lat_be    <= req_byte_enable;
        lat_data  <= req_write_data;
      end
    end
  end

  // Backing array: lane-masked write, never reset
  always_ff @(posedge clock) begin
    if (mem_we_c) begin
      for (int b = 0; b < 4; b++) begin
        if (lat_be[b]) mem[lat_idx][8*b +: 8] <= lat_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_bus_responder.sv
// Scoreboard bench for data_bus_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance.
module tb_data_bus_responder;

  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam int          DEPTH = 1024;

  typedef struct {
    logic        wr;
    logic        err;
    int          idx;
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] rdata;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n, req_valid, req_write, resp_ready, sel;
  logic [31:0] req_address, req_write_data;
  logic [3:0]  req_byte_enable;
  logic        rr_a, rv_a, re_a, rr_b, rv_b, re_b;
  logic [31:0] rd_a, rd_b;
  logic        req_ready, resp_valid, resp_error;
  logic [31:0] resp_read_data;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t sbq[$];
  logic [31:0] mdl [2][DEPTH];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  assign req_ready      = sel ? rr_b : rr_a;
  assign resp_valid     = sel ? rv_b : rv_a;
  assign resp_error     = sel ? re_b : re_a;
  assign resp_read_data = sel ? rd_b : rd_a;

  data_bus_responder #(.BASE_ADDRESS(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) u_a (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid & ~sel), .req_ready(rr_a), .req_write(req_write),
    .req_address(req_address), .req_byte_enable(req_byte_enable), .req_write_data(req_write_data),
    .resp_valid(rv_a), .resp_ready(resp_ready & ~sel), .resp_read_data(rd_a), .resp_error(re_a)
  );

  data_bus_responder #(.BASE_ADDRESS(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_b (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid & sel), .req_ready(rr_b), .req_write(req_write),
    .req_address(req_address), .req_byte_enable(req_byte_enable), .req_write_data(req_write_data),
    .resp_valid(rv_b), .resp_ready(resp_ready & sel), .resp_read_data(rd_b), .resp_error(re_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  // Issue one request from a negedge; returns at the negedge after the response handshake.
  task automatic send(input logic wr, input logic [31:0] addr, input logic [3:0] be,
                      input logic [31:0] data, input int hold, output int acc_cyc);
    exp_t        e;
    int          n;
    longint      off;
    logic [31:0] h_d, w;
    logic        h_e, legal;
    req_valid = 1'b1; req_write = wr; req_address = addr;
    req_byte_enable = be; req_write_data = data;
    resp_ready = (hold == 0);
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clock); n++; end
    if (!req_ready) begin
      check("accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      acc_cyc = 0;
      return;
    end
    acc_cyc = cyc + 1;
    off   = longint'(addr) - longint'(BASE);
    legal = (be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111});
    e.wr = wr; e.be = be; e.data = data;
    e.err = (off < 0) || (off >= 4 * DEPTH) || !legal;
    e.idx = e.err ? 0 : int'(off >>> 2);
    e.rdata = (wr || e.err) ? 32'h0 : mdl[sel][e.idx];
    sbq.push_back(e);
    @(negedge clock);
    // Scramble request inputs after acceptance; only a held-response request keeps req_valid up.
    req_valid = (hold > 0);
    req_address = ~addr; req_write_data = ~data; req_byte_enable = ~be; req_write = ~wr;
    n = 0;
    while (!resp_valid && n < 20) begin @(negedge clock); n++; end
    if (!resp_valid) begin
      check("resp_timeout", 32'(resp_valid), 32'd1);
      void'(sbq.pop_front());
      req_valid = 1'b0;
      return;
    end
    // Acceptance cycle counts as cycle 0.
    check("latency", 32'(cyc - acc_cyc + 1), 32'(sel ? 2 : 4));
    if (hold > 0) begin
      h_d = resp_read_data; h_e = resp_error;
      for (int i = 0; i < hold; i++) begin
        @(negedge clock);
        check("hold_valid", 32'(resp_valid), 32'd1);
        check("hold_data", resp_read_data, h_d);
        check("hold_err", 32'(resp_error), 32'(h_e));
        check("hold_req_ready", 32'(req_ready), 32'd0);
      end
    end
    resp_ready = 1'b1;
    req_valid = 1'b0;
    e = sbq.pop_front();
    check("resp_data", resp_read_data, e.rdata);
    check("resp_err", 32'(resp_error), 32'(e.err));
    if (e.wr && !e.err) begin
      w = mdl[sel][e.idx];
      for (int b = 0; b < 4; b++) if (e.be[b]) w[8*b +: 8] = e.data[8*b +: 8];
      mdl[sel][e.idx] = w;
    end
    @(negedge clock);
    check("resp_cleared", 32'(resp_valid), 32'd0);
    check("idle_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, dummy;
    logic seen;
    reset_n = 1'b0; sel = 1'b0; req_valid = 1'b0; req_write = 1'b0; resp_ready = 1'b0;
    req_address = 32'h0; req_byte_enable = 4'h0; req_write_data = 32'h0;
    repeat (3) @(negedge clock);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data", resp_read_data, 32'h0);
    check("rst_resp_err", 32'(resp_error), 32'd0);
    sel = 1'b1;
    #1;
    check("rst_b_req_ready", 32'(req_ready), 32'd1);
    check("rst_b_resp_valid", 32'(resp_valid), 32'd0);
    sel = 1'b0;
    reset_n = 1'b1;
    @(negedge clock);

    // Full-word store/load, then a byte merge
    send(1'b1, 32'h0001_0010, 4'b1111, 32'hDEAD_BEEF, 0, dummy);
    send(1'b0, 32'h0001_0010, 4'b1111, 32'h0, 0, dummy);
    send(1'b1, 32'h0001_0011, 4'b0010, 32'h0000_5500, 0, dummy);
    send(1'b0, 32'h0001_0010, 4'b1111, 32'h0, 0, dummy);

    // Error cases leave the array untouched
    send(1'b0, 32'h0000_FFFC, 4'b1111, 32'h0, 0, dummy);
    send(1'b0, 32'h0001_1000, 4'b1111, 32'h0, 0, dummy);
    send(1'b1, 32'h0001_0010, 4'b0110, 32'hFFFF_FFFF, 0, dummy);
    send(1'b1, 32'h0001_0010, 4'b0000, 32'hFFFF_FFFF, 0, dummy);
    send(1'b0, 32'h0001_0010, 4'b1111, 32'h0, 0, dummy);

    // Last word in range, upper halfword store
    send(1'b1, 32'h0001_0FFC, 4'b1111, 32'hA5A5_A5A5, 0, dummy);
    send(1'b1, 32'h0001_0FFE, 4'b1100, 32'h1234_0000, 0, dummy);
    send(1'b0, 32'h0001_0FFC, 4'b0001, 32'h0, 0, dummy);

    // Response held for 5 cycles with req_valid kept high
    send(1'b0, 32'h0001_0010, 4'b1111, 32'h0, 5, dummy);

    // Reset pulsed during WAIT drops the store and its response
    req_valid = 1'b1; req_write = 1'b1; req_address = 32'h0001_0010;
    req_byte_enable = 4'b1111; req_write_data = 32'h0BAD_F00D; resp_ready = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    check("rst_mid_req_ready", 32'(req_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      seen = seen | resp_valid;
    end
    check("rst_mid_no_resp", 32'(seen), 32'd0);
    send(1'b0, 32'h0001_0010, 4'b1111, 32'h0, 0, dummy);

    // Zero-wait instance: back-to-back loads, one acceptance every 3 cycles
    sel = 1'b1;
    for (int i = 0; i < 4; i++)
      send(1'b1, BASE + 32'(4 * (i + 7)), 4'b1111, 32'hC0DE_0000 + 32'(i * 32'h111), 0, dummy);
    send(1'b0, BASE + 32'(4 * 7), 4'b1111, 32'h0, 0, a0);
    for (int i = 1; i < 4; i++) begin
      send(1'b0, BASE + 32'(4 * (i + 7)), 4'b1111, 32'h0, 0, a1);
      check("b2b_spacing", 32'(a1 - a0), 32'd3);
      a0 = a1;
    end
    send(1'b0, BASE + 32'(4 * DEPTH), 4'b1111, 32'h0, 0, dummy);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
